// File: rtl/axis_out_packer.sv
// AXI-Stream output packer: compacts sparse-tkeep beats into dense full beats,
// emitting a partial beat only to close a packet. Optional `AXIS_OUT_PACKER_COUNT_EN adds o_packet_words.
module axis_out_packer #(
  parameter int Y_BITS = 32,
  parameter int LANES  = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [LANES*Y_BITS-1:0] s_axis_tdata,
  input  logic [LANES-1:0]        s_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [LANES*Y_BITS-1:0] m_axis_tdata,
  output logic [LANES-1:0]        m_axis_tkeep
`ifdef AXIS_OUT_PACKER_COUNT_EN
  ,
  output logic [31:0]             o_packet_words
`endif
);

  localparam int DEPTH = 2 * LANES;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int IW    = $clog2(DEPTH);

  logic [Y_BITS-1:0] buf_q [DEPTH];
  logic [Y_BITS-1:0] buf_d [DEPTH];
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     out_n, pop_n, add_n, idx;
  logic              flush_q, flush_d;
  logic              push, pop;
  int unsigned       src;

  assign out_n         = (count_q >= CW'(LANES)) ? CW'(LANES) : count_q;
  assign s_axis_tready = !flush_q && (count_q <= CW'(LANES));
  assign m_axis_tvalid = (count_q >= CW'(LANES)) || flush_q;
  assign m_axis_tlast  = flush_q && (count_q <= CW'(LANES));
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign pop_n         = pop ? out_n : '0;

  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (CW'(i) < out_n) begin
        m_axis_tdata[i*Y_BITS +: Y_BITS] = buf_q[i];
        m_axis_tkeep[i]                  = 1'b1;
      end
    end
  end

  // Pop shifts the buffer down first; kept input words then land after the survivors.
  always_comb begin
    src     = 0;
    idx     = count_q - pop_n;
    add_n   = '0;
    flush_d = flush_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      src      = i + 32'(pop_n);
      buf_d[i] = '0;
      if (src < DEPTH) buf_d[i] = buf_q[IW'(src)];
    end
    if (push) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        if (s_axis_tkeep[j]) begin
          if (idx < CW'(DEPTH)) buf_d[IW'(idx)] = s_axis_tdata[j*Y_BITS +: Y_BITS];
          idx   = idx + CW'(1);
          add_n = add_n + CW'(1);
        end
      end
    end
    count_d = count_q - pop_n + add_n;
    if (pop && m_axis_tlast) flush_d = 1'b0;
    if (push && s_axis_tlast) flush_d = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_q <= '0;
      flush_q <= 1'b0;
    end else begin
      count_q <= count_d;
      flush_q <= flush_d;
    end
  end

  // Word storage needs no reset: lanes beyond count are masked on the output.
  always_ff @(posedge aclk) begin
    for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= buf_d[i];
  end

`ifdef AXIS_OUT_PACKER_COUNT_EN
  logic [31:0] acc_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q          <= '0;
      o_packet_words <= '0;
    end else if (pop) begin
      if (m_axis_tlast) begin
        o_packet_words <= acc_q + 32'(out_n);
        acc_q          <= '0;
      end else begin
        acc_q <= acc_q + 32'(out_n);
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_out_packer.sv
// Directed and randomised checks of axis_out_packer with LANES=4, Y_BITS=32.
module tb_axis_out_packer;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   k;
    logic         l;
  } beat_t;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [127:0] s_axis_tdata = '0;
  logic [3:0]   s_axis_tkeep = '0;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;
  logic [127:0] m_axis_tdata;
  logic [3:0]   m_axis_tkeep;
`ifdef AXIS_OUT_PACKER_COUNT_EN
  logic [31:0]  o_packet_words;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  beat_t        out_b[$];
  logic [31:0]  got_w[$];
  logic [31:0]  exp_w[$];
  int unsigned  got_tot[$];
  int unsigned  exp_tot[$];
  int unsigned  acc = 0;
  int unsigned  bad_keep = 0;
  int unsigned  stab_bad = 0;
  logic         prev_stall = 1'b0;
  beat_t        prev_b;
  logic         stress_done = 1'b0;

  axis_out_packer #(.Y_BITS(32), .LANES(4)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep)
`ifdef AXIS_OUT_PACKER_COUNT_EN
    ,
    .o_packet_words(o_packet_words)
`endif
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Output monitor: samples on the falling edge, the handshake completes at the next rising edge.
  always @(negedge aclk) begin
    if (!aresetn) begin
      acc        = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_b.d ||
                         m_axis_tkeep !== prev_b.k || m_axis_tlast !== prev_b.l))
        stab_bad++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_b     = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      if (m_axis_tvalid && m_axis_tready) begin
        out_b.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast});
        if (!(m_axis_tkeep inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF})) bad_keep++;
        for (int unsigned i = 0; i < 4; i++) begin
          if (m_axis_tkeep[i]) begin
            got_w.push_back(m_axis_tdata[i*32 +: 32]);
            acc++;
          end
        end
        if (m_axis_tlast) begin
          got_tot.push_back(acc);
          acc = 0;
        end
      end
    end
  end

  function automatic logic [127:0] mk(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [127:0] d, input logic [3:0] k, input logic l);
    int unsigned n = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_axis_tready && n < 300) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 300) chk("send_timeout", 128'(n), 128'(0));
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_beats(input int unsigned nb, input string tag);
    int unsigned c = 0;
    while (out_b.size() < nb && c < 300) begin
      @(negedge aclk);
      c++;
    end
    repeat (5) @(posedge aclk);
    #1;
    chk(tag, 128'(out_b.size()), 128'(nb));
  endtask

  task automatic chk_beat(input int unsigned i, input string tag, input logic [127:0] d,
                          input logic [3:0] k, input logic l);
    if (out_b.size() > i) begin
      chk({tag, "_data"}, out_b[i].d, d);
      chk({tag, "_keep"}, 128'(out_b[i].k), 128'(k));
      chk({tag, "_last"}, 128'(out_b[i].l), 128'(l));
    end else begin
      chk({tag, "_missing"}, 128'(out_b.size()), 128'(i + 1));
    end
  endtask

  task automatic clear_q();
    out_b.delete();
    got_w.delete();
    got_tot.delete();
  endtask

  initial begin
    logic [127:0] d;
    logic [3:0]   k;
    int unsigned  nb, tot, mism;

    // Reset values
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_s_tready", 128'(s_axis_tready), 128'(1));
    chk("rst_m_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst_m_tlast",  128'(m_axis_tlast),  128'(0));
    chk("rst_m_tdata",  m_axis_tdata,        128'(0));
    chk("rst_m_tkeep",  128'(m_axis_tkeep),  128'(0));
`ifdef AXIS_OUT_PACKER_COUNT_EN
    chk("rst_words", 128'(o_packet_words), 128'(0));
`endif
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Dense passthrough; last beat closes with exactly LANES words buffered
    m_axis_tready = 1'b1;
    clear_q();
    send(mk(0, 1, 2, 3), 4'hF, 1'b0);
    chk("dense_lat_valid", 128'(m_axis_tvalid), 128'(1));
    send(mk(4, 5, 6, 7), 4'hF, 1'b0);
    send(mk(8, 9, 10, 11), 4'hF, 1'b1);
    wait_beats(3, "dense_nbeats");
    chk_beat(0, "dense_b0", mk(0, 1, 2, 3), 4'hF, 1'b0);
    chk_beat(1, "dense_b1", mk(4, 5, 6, 7), 4'hF, 1'b0);
    chk_beat(2, "dense_b2", mk(8, 9, 10, 11), 4'hF, 1'b1);
`ifdef AXIS_OUT_PACKER_COUNT_EN
    chk("dense_words", 128'(o_packet_words), 128'(12));
`endif

    // Sparse compaction, including an empty non-last beat
    clear_q();
    send(mk(32'hA, 32'hDEAD, 32'hB, 32'hDEAD), 4'b0101, 1'b0);
    send(mk(32'hBAD0, 32'hBAD1, 32'hBAD2, 32'hBAD3), 4'b0000, 1'b0);
    send(mk(32'hDEAD, 32'hC, 32'hD, 32'hE), 4'b1110, 1'b0);
    send(mk(32'hF, 32'hDEAD, 32'hDEAD, 32'hDEAD), 4'b0001, 1'b1);
    wait_beats(2, "sparse_nbeats");
    chk_beat(0, "sparse_b0", mk(32'hA, 32'hB, 32'hC, 32'hD), 4'hF, 1'b0);
    chk_beat(1, "sparse_b1", mk(32'hE, 32'hF, 0, 0), 4'h3, 1'b1);
`ifdef AXIS_OUT_PACKER_COUNT_EN
    chk("sparse_words", 128'(o_packet_words), 128'(6));
`endif

    // Empty last on an idle buffer
    clear_q();
    send(mk(32'h11, 32'h22, 32'h33, 32'h44), 4'h0, 1'b1);
    wait_beats(1, "empty_nbeats");
    chk_beat(0, "empty_b0", 128'(0), 4'h0, 1'b1);
`ifdef AXIS_OUT_PACKER_COUNT_EN
    chk("empty_words", 128'(o_packet_words), 128'(0));
`endif

    // Backpressure during a dense stream
    clear_q();
    m_axis_tready = 1'b0;
    fork
      begin
        send(mk(16, 17, 18, 19), 4'hF, 1'b0);
        send(mk(20, 21, 22, 23), 4'hF, 1'b0);
        send(mk(24, 25, 26, 27), 4'hF, 1'b1);
      end
      begin
        repeat (3) @(negedge aclk);
        chk("bp_s_tready_low", 128'(s_axis_tready), 128'(0));
        chk("bp_hold_data0", m_axis_tdata, mk(16, 17, 18, 19));
        repeat (7) @(negedge aclk);
        chk("bp_hold_valid", 128'(m_axis_tvalid), 128'(1));
        chk("bp_hold_data1", m_axis_tdata, mk(16, 17, 18, 19));
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
      end
    join
    wait_beats(3, "bp_nbeats");
    chk_beat(0, "bp_b0", mk(16, 17, 18, 19), 4'hF, 1'b0);
    chk_beat(1, "bp_b1", mk(20, 21, 22, 23), 4'hF, 1'b0);
    chk_beat(2, "bp_b2", mk(24, 25, 26, 27), 4'hF, 1'b1);
    chk("bp_stable", 128'(stab_bad), 128'(0));

    // Flush with more than LANES words buffered: full beat first, then remainder
    clear_q();
    m_axis_tready = 1'b0;
    send(mk(40, 41, 42, 43), 4'hF, 1'b0);
    send(mk(44, 45, 46, 47), 4'b0110, 1'b1);
    chk("fgt_s_tready_low", 128'(s_axis_tready), 128'(0));
    chk("fgt_tlast_first", 128'(m_axis_tlast), 128'(0));
    m_axis_tready = 1'b1;
    wait_beats(2, "fgt_nbeats");
    chk_beat(0, "fgt_b0", mk(40, 41, 42, 43), 4'hF, 1'b0);
    chk_beat(1, "fgt_b1", mk(45, 46, 0, 0), 4'h3, 1'b1);

    // Reset mid-packet with 5 words buffered
    clear_q();
    m_axis_tready = 1'b0;
    send(mk(50, 51, 52, 53), 4'hF, 1'b0);
    send(mk(54, 55, 56, 57), 4'b0001, 1'b0);
    chk("mid_valid_before", 128'(m_axis_tvalid), 128'(1));
    aresetn = 1'b0;
    #1;
    chk("mid_s_tready", 128'(s_axis_tready), 128'(1));
    chk("mid_m_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("mid_m_tlast",  128'(m_axis_tlast),  128'(0));
    chk("mid_m_tdata",  m_axis_tdata,        128'(0));
    chk("mid_m_tkeep",  128'(m_axis_tkeep),  128'(0));
`ifdef AXIS_OUT_PACKER_COUNT_EN
    chk("mid_words", 128'(o_packet_words), 128'(0));
`endif
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    m_axis_tready = 1'b1;
    send(mk(60, 61, 62, 63), 4'hF, 1'b1);
    wait_beats(1, "mid_nbeats");
    chk_beat(0, "mid_b0", mk(60, 61, 62, 63), 4'hF, 1'b1);
`ifdef AXIS_OUT_PACKER_COUNT_EN
    chk("mid_words_after", 128'(o_packet_words), 128'(4));
`endif

    // Random stress: 50% valid, 50% ready, random tkeep
    clear_q();
    stab_bad = 0;
    bad_keep = 0;
    fork
      begin
        for (int unsigned p = 0; p < 200; p++) begin
          nb  = $urandom_range(1, 3);
          tot = 0;
          for (int unsigned b = 0; b < nb; b++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            k = 4'($urandom_range(0, 15));
            for (int unsigned i = 0; i < 4; i++) begin
              if (k[i]) begin
                exp_w.push_back(d[i*32 +: 32]);
                tot++;
              end
            end
            while ($urandom_range(0, 1) == 0) begin
              @(posedge aclk);
              #1;
            end
            send(d, k, b == nb - 1);
          end
          exp_tot.push_back(tot);
        end
        stress_done = 1'b1;
      end
      begin
        while (!stress_done) begin
          @(posedge aclk);
          #1;
          m_axis_tready = ($urandom_range(0, 1) == 1);
        end
        m_axis_tready = 1'b1;
      end
    join
    begin
      int unsigned c = 0;
      while (got_tot.size() < 200 && c < 2000) begin
        @(negedge aclk);
        c++;
      end
    end
    repeat (5) @(posedge aclk);
    #1;
    chk("rnd_packets", 128'(got_tot.size()), 128'(200));
    chk("rnd_nwords", 128'(got_w.size()), 128'(exp_w.size()));
    mism = 0;
    for (int unsigned i = 0; i < exp_w.size(); i++)
      if (i >= got_w.size() || got_w[i] !== exp_w[i]) mism++;
    chk("rnd_word_order", 128'(mism), 128'(0));
    mism = 0;
    for (int unsigned i = 0; i < exp_tot.size(); i++)
      if (i >= got_tot.size() || got_tot[i] != exp_tot[i]) mism++;
    chk("rnd_pkt_sizes", 128'(mism), 128'(0));
    chk("rnd_keep_contig", 128'(bad_keep), 128'(0));
    chk("rnd_stable", 128'(stab_bad), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
